// File: rtl/unified_mem_model.sv
// Behavioural instruction/data memory for RV32E benches: split or shared storage,
// per-port read latency pipelines, out-of-range handling and byte-lane writes.
module unified_mem_model #(
  parameter int DEPTH    = 2**16,
  parameter int INST_LAT = 1,
  parameter int DATA_LAT = 1,
  parameter int SHARED   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_addr,
  output logic [31:0] instruction,
  output logic        inst_ready,
  input  logic        sram_cen,
  input  logic        sram_wen,
  input  logic [3:0]  sram_ben,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_din,
  output logic [31:0] sram_dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int IDEPTH = (SHARED != 0) ? 1 : DEPTH;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [3:0][7:0] dmem [DEPTH];
  logic [3:0][7:0] imem [IDEPTH];

  logic [AW-1:0] inst_idx;
  logic [AW-1:0] data_idx;
  logic          inst_oor;
  logic          data_oor;
  logic          data_access;
  logic          data_write;
  logic [31:0]   inst_word;
  logic [31:0]   inst_rd_data;
  logic [31:0]   data_rd_data;
  logic          fetch_go;
  logic          unused_addr_bits;

  assign inst_idx    = inst_addr[AW+1:2];
  assign data_idx    = sram_addr[AW+1:2];
  assign inst_oor    = |inst_addr[31:AW+2];
  assign data_oor    = |sram_addr[31:AW+2];
  assign data_access = ~sram_cen;
  assign data_write  = data_access & ~sram_wen & ~data_oor;

  assign unused_addr_bits = &{1'b0, inst_addr[1:0], sram_addr[1:0]};

  // Shared mode: one single-ported array, so a data access steals the fetch slot.
  generate
    if (SHARED != 0) begin : g_shared
      assign inst_word = dmem[inst_idx];
      assign fetch_go  = sram_cen;
    end else begin : g_split
      assign inst_word = imem[inst_idx];
      assign fetch_go  = 1'b1;
    end
  endgenerate

  assign inst_rd_data = inst_oor ? NOP : inst_word;
  assign data_rd_data = (data_access && !data_oor) ? dmem[data_idx] : 32'h0;

  // Reads above sample the array before this edge's write lands: read-before-write.
  always_ff @(posedge clk) begin
    if (rst_n && data_write) begin
      for (int b = 0; b < 4; b++) begin
        if (!sram_ben[b]) dmem[data_idx][b] <= sram_din[8*b +: 8];
      end
    end
  end

  // Fetch pipeline: data only advances with a valid slot, so the last stage
  // holds the previous instruction across suppressed fetches.
  generate
    for (genvar gi = 0; gi < INST_LAT; gi++) begin : g_inst_pipe
      logic        in_v;
      logic [31:0] in_d;
      logic        v_reg;
      logic [31:0] d_reg;

      if (gi == 0) begin : g_head
        assign in_v = fetch_go;
        assign in_d = inst_rd_data;
      end else begin : g_tail
        assign in_v = g_inst_pipe[gi-1].v_reg;
        assign in_d = g_inst_pipe[gi-1].d_reg;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_reg <= 1'b0;
          d_reg <= NOP;
        end else begin
          v_reg <= in_v;
          if (in_v) d_reg <= in_d;
        end
      end
    end
  endgenerate

  assign inst_ready  = g_inst_pipe[INST_LAT-1].v_reg;
  assign instruction = g_inst_pipe[INST_LAT-1].d_reg;

  generate
    for (genvar gi = 0; gi < DATA_LAT; gi++) begin : g_data_pipe
      logic        in_v;
      logic [31:0] in_d;
      logic        v_reg;
      logic [31:0] d_reg;

      if (gi == 0) begin : g_head
        assign in_v = data_access;
        assign in_d = data_rd_data;
      end else begin : g_tail
        assign in_v = g_data_pipe[gi-1].v_reg;
        assign in_d = g_data_pipe[gi-1].d_reg;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_reg <= 1'b0;
          d_reg <= 32'h0;
        end else begin
          v_reg <= in_v;
          d_reg <= in_v ? in_d : 32'h0;
        end
      end
    end
  endgenerate

  assign sram_dout = g_data_pipe[DATA_LAT-1].v_reg ? g_data_pipe[DATA_LAT-1].d_reg : 32'h0;

endmodule

// File: tb/tb_unified_mem_model.sv
// Bench for unified_mem_model: a split instance (slow latencies, small depth)
// and a shared instance for arbitration; data reads of the split one go through a scoreboard.
module tb_unified_mem_model;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int A_DLAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [31:0] a_inst_addr, a_instruction, a_addr, a_din, a_dout;
  logic        a_inst_ready, a_cen, a_wen;
  logic [3:0]  a_ben;
  logic [31:0] b_inst_addr, b_instruction, b_addr, b_din, b_dout;
  logic        b_inst_ready, b_cen, b_wen;
  logic [3:0]  b_ben;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int txn_id = 0;

  typedef struct {
    logic [31:0] exp;
    int          due;
    int          id;
  } item_t;
  item_t sb[$];

  unified_mem_model #(.DEPTH(1024), .INST_LAT(3), .DATA_LAT(A_DLAT), .SHARED(0)) a_dut (
    .clk(clk), .rst_n(rst_n),
    .inst_addr(a_inst_addr), .instruction(a_instruction), .inst_ready(a_inst_ready),
    .sram_cen(a_cen), .sram_wen(a_wen), .sram_ben(a_ben),
    .sram_addr(a_addr), .sram_din(a_din), .sram_dout(a_dout)
  );

  unified_mem_model #(.DEPTH(1024), .INST_LAT(1), .DATA_LAT(1), .SHARED(1)) b_dut (
    .clk(clk), .rst_n(rst_n),
    .inst_addr(b_inst_addr), .instruction(b_instruction), .inst_ready(b_inst_ready),
    .sram_cen(b_cen), .sram_wen(b_wen), .sram_ben(b_ben),
    .sram_addr(b_addr), .sram_din(b_din), .sram_dout(b_dout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    edge_cnt++;
    while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
      item_t it;
      it = sb.pop_front();
      checks++;
      if (a_dout !== it.exp) begin
        errors++;
        $display("FAIL dout_txn%0d: got %h expected %h", it.id, a_dout, it.exp);
      end else begin
        $display("ok   dout_txn%0d: %h", it.id, a_dout);
      end
    end
  endtask

  task automatic data_idle();
    a_cen = 1'b1;
    a_wen = 1'b1;
    a_ben = 4'hF;
  endtask

  task automatic data_op(input logic wen, input logic [3:0] ben, input logic [31:0] addr,
                         input logic [31:0] din, input logic [31:0] exp);
    item_t it;
    a_cen  = 1'b0;
    a_wen  = wen;
    a_ben  = ben;
    a_addr = addr;
    a_din  = din;
    it.exp = exp;
    it.due = edge_cnt + A_DLAT;
    it.id  = txn_id;
    txn_id++;
    sb.push_back(it);
    tick();
  endtask

  task automatic drain();
    data_idle();
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending %0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    a_inst_addr = 32'h4;
    b_inst_addr = 32'h0;
    data_idle();
    a_addr = 0; a_din = 0;
    b_cen = 1'b1; b_wen = 1'b1; b_ben = 4'hF; b_addr = 0; b_din = 0;
    #2;
    a_dut.imem[1] = 32'h0050_0093;
    a_dut.imem[0] = 32'h0010_0073;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (a_instruction !== NOP || a_inst_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_inst: got %h/%b expected %h/0", a_instruction, a_inst_ready, NOP);
    end
    if (a_dout !== 32'h0) begin
      errors++;
      $display("FAIL reset_dout: got %h expected 0", a_dout);
    end
    if (b_instruction !== NOP || b_inst_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_inst_b: got %h/%b expected %h/0", b_instruction, b_inst_ready, NOP);
    end
    if (b_dout !== 32'h0) begin
      errors++;
      $display("FAIL reset_dout_b: got %h expected 0", b_dout);
    end
    $display("reset state checked");
    rst_n = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      logic        exp_rdy;
      logic [31:0] exp_ins;
      tick();
      exp_rdy = (e >= 3);
      exp_ins = (e >= 3) ? 32'h0050_0093 : NOP;
      checks++;
      if (a_inst_ready !== exp_rdy || a_instruction !== exp_ins) begin
        errors++;
        $display("FAIL fetch_latency_edge%0d: got %h/%b expected %h/%b",
                 e, a_instruction, a_inst_ready, exp_ins, exp_rdy);
      end else begin
        $display("ok   fetch edge %0d: %h ready=%b", e, a_instruction, a_inst_ready);
      end
    end
  endtask

  task automatic test_byte_lanes();
    data_op(1'b0, 4'b0000, 32'h10, 32'hAABB_CCDD, 32'h0);
    sb.pop_back();
    data_op(1'b0, 4'b1010, 32'h10, 32'h1122_3344, 32'hAABB_CCDD);
    data_op(1'b1, 4'b0000, 32'h10, 32'h0, 32'hAA22_CC44);
    drain();
  endtask

  task automatic test_read_before_write();
    a_dut.dmem[8] = 32'h0;
    data_op(1'b0, 4'b0000, 32'h20, 32'h1234_5678, 32'h0);
    data_op(1'b1, 4'b0000, 32'h20, 32'h0, 32'h1234_5678);
    drain();
  endtask

  task automatic test_back_to_back();
    a_dut.dmem[12] = 32'h0BAD_0BAD;
    data_op(1'b0, 4'b0000, 32'h30, 32'h0000_0001, 32'h0BAD_0BAD);
    data_op(1'b0, 4'b0000, 32'h30, 32'h0000_0002, 32'h0000_0001);
    data_op(1'b1, 4'b0000, 32'h30, 32'h0, 32'h0000_0002);
    data_idle();
    tick();
    drain();
  endtask

  task automatic test_out_of_range();
    a_dut.dmem[0] = 32'hCAFE_F00D;
    data_op(1'b0, 4'b0000, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0);
    data_op(1'b1, 4'b0000, 32'h0000_1000, 32'h0, 32'h0);
    data_op(1'b1, 4'b0000, 32'h0000_0000, 32'h0, 32'hCAFE_F00D);
    drain();
    checks++;
    if (a_dut.dmem[0] !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL oor_write_dropped: got %h expected %h", a_dut.dmem[0], 32'hCAFE_F00D);
    end else begin
      $display("ok   oor write dropped, dmem[0]=%h", a_dut.dmem[0]);
    end
    a_inst_addr = 32'h0000_1000;
    repeat (3) tick();
    checks++;
    if (a_instruction !== NOP || a_inst_ready !== 1'b1) begin
      errors++;
      $display("FAIL oor_fetch: got %h/%b expected %h/1", a_instruction, a_inst_ready, NOP);
    end else begin
      $display("ok   oor fetch: %h ready=%b", a_instruction, a_inst_ready);
    end
    a_inst_addr = 32'h4;
  endtask

  task automatic test_shared();
    logic [31:0] words [4];
    logic [31:0] exp_dout [3];
    logic [31:0] op_addr [3];
    words[0] = 32'h1111_0000;
    words[1] = 32'h2222_0001;
    words[2] = 32'h3333_0002;
    words[3] = 32'h4444_0003;
    for (int i = 0; i < 4; i++) b_dut.dmem[i] = words[i];
    tick();
    checks++;
    if (b_inst_ready !== 1'b1 || b_instruction !== words[0]) begin
      errors++;
      $display("FAIL shared_fetch0: got %h/%b expected %h/1", b_instruction, b_inst_ready, words[0]);
    end
    b_inst_addr = 32'h4;
    op_addr[0] = 32'h4;  exp_dout[0] = words[1];
    op_addr[1] = 32'h8;  exp_dout[1] = words[2];
    op_addr[2] = 32'hC;  exp_dout[2] = words[3];
    for (int i = 0; i < 3; i++) begin
      b_cen  = 1'b0;
      b_wen  = (i == 0) ? 1'b0 : 1'b1;
      b_ben  = 4'b0000;
      b_addr = op_addr[i];
      b_din  = 32'hDEAD_BEEF;
      tick();
      checks++;
      if (b_inst_ready !== 1'b0 || b_instruction !== words[0] || b_dout !== exp_dout[i]) begin
        errors++;
        $display("FAIL shared_stall%0d: got inst %h/%b dout %h expected inst %h/0 dout %h",
                 i, b_instruction, b_inst_ready, b_dout, words[0], exp_dout[i]);
      end else begin
        $display("ok   shared stall %0d: dout %h", i, b_dout);
      end
    end
    b_cen = 1'b1;
    b_wen = 1'b1;
    tick();
    checks++;
    if (b_inst_ready !== 1'b1 || b_instruction !== 32'hDEAD_BEEF || b_dout !== 32'h0) begin
      errors++;
      $display("FAIL shared_resume: got %h/%b dout %h expected deadbeef/1 dout 0",
               b_instruction, b_inst_ready, b_dout);
    end else begin
      $display("ok   shared resume: %h", b_instruction);
    end
  endtask

  task automatic test_reset_midflight();
    a_cen  = 1'b0;
    a_wen  = 1'b1;
    a_ben  = 4'b0000;
    a_addr = 32'h10;
    tick();
    tick();
    data_idle();
    tick();
    tick();
    checks++;
    if (a_dout !== 32'hAA22_CC44) begin
      errors++;
      $display("FAIL midflight_pre: got %h expected %h", a_dout, 32'hAA22_CC44);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_dout !== 32'h0) begin
      errors++;
      $display("FAIL midflight_async: got %h expected 0", a_dout);
    end
    a_cen  = 1'b0;
    a_wen  = 1'b0;
    a_din  = 32'h0;
    repeat (2) tick();
    data_idle();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (a_dout !== 32'h0) begin
        errors++;
        $display("FAIL midflight_stale%0d: got %h expected 0", i, a_dout);
      end
    end
    $display("mid-flight reset checked");
    data_op(1'b1, 4'b0000, 32'h10, 32'h0, 32'hAA22_CC44);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_byte_lanes();
    test_read_before_write();
    test_back_to_back();
    test_out_of_range();
    test_shared();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
